// File: rtl/rc_charge_sequencer.sv
// Single-slope RC time-constant meter: dump C, charge through R, count cycles
// until the synchronised comparator trips, then report count and fault flags.
module rc_charge_sequencer #(
    parameter int CNT_W        = 16,
    parameter int DISCH_CYCLES = 64,
    parameter int TIMEOUT      = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             drive_en,
    output logic             dump_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             timeout_flag,
    output logic             precharge_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DISCH  = 3'd1;
    localparam logic [2:0] ST_GAP1   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_CHARGE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [CNT_W-1:0] DISCH_LAST = CNT_W'(DISCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             timeout_flag_q, timeout_flag_d;
    logic             precharge_err_q, precharge_err_d;
    logic             drive_en_q, drive_en_d;
    logic             dump_en_q, dump_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sync1_q, sync2_q;
    logic             cmp_s;

    assign cmp_s = sync2_q;

    // Next-state, counter and result logic; one counter serves as the
    // discharge timer and the charge counter since the phases never overlap.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        count_d         = count_q;
        timeout_flag_d  = timeout_flag_q;
        precharge_err_d = precharge_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_DISCH;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DISCH_LAST) begin
                    state_d = ST_GAP1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP1: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cmp_s) begin
                    state_d         = ST_DONE;
                    count_d         = CNT_ZERO;
                    timeout_flag_d  = 1'b0;
                    precharge_err_d = 1'b1;
                end else begin
                    state_d = ST_CHARGE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_CHARGE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cmp_s) begin
                    state_d         = ST_DONE;
                    count_d         = cnt_q;
                    timeout_flag_d  = 1'b0;
                    precharge_err_d = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d         = ST_DONE;
                    count_d         = TIMEOUT_C;
                    timeout_flag_d  = 1'b1;
                    precharge_err_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops track the state;
    // the GAP1/CHECK states give break-before-make between the two switches.
    always_comb begin
        drive_en_d = (state_d == ST_CHARGE);
        dump_en_d  = (state_d == ST_DISCH);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    // State, result and comparator synchroniser registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= CNT_ZERO;
            count_q         <= CNT_ZERO;
            timeout_flag_q  <= 1'b0;
            precharge_err_q <= 1'b0;
            drive_en_q      <= 1'b0;
            dump_en_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            count_q         <= count_d;
            timeout_flag_q  <= timeout_flag_d;
            precharge_err_q <= precharge_err_d;
            drive_en_q      <= drive_en_d;
            dump_en_q       <= dump_en_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            sync1_q         <= cmp_in;
            sync2_q         <= sync1_q;
        end
    end

    assign drive_en      = drive_en_q;
    assign dump_en       = dump_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign count         = count_q;
    assign timeout_flag  = timeout_flag_q;
    assign precharge_err = precharge_err_q;

endmodule
